// File: rtl/id_stage_if.sv
// Bundles the decode stage's fetch, register-file, writeback and ID/EX signals.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface id_stage_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_stall;
    logic        ex_flush;

    logic [4:0]  rnum1;
    logic [4:0]  rnum2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [4:0]  wb_wnum;
    logic [31:0] wb_wdata;
    logic        wb_regwrite;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1val;
    logic [31:0] ex_rs2val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_alusrc;
    logic        ex_asel_pc;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_regwrite;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_lui;
    logic        ex_illegal;
    logic [31:0] perf_stalls;

    modport slave (
        input  if_valid, if_pc, if_instr, ex_flush,
        input  rdata1, rdata2, wb_wnum, wb_wdata, wb_regwrite,
        output id_stall, rnum1, rnum2,
        output ex_valid, ex_pc, ex_rs1val, ex_rs2val, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
        output ex_alusrc, ex_asel_pc, ex_memread, ex_memwrite, ex_regwrite,
        output ex_branch, ex_jal, ex_jalr, ex_lui, ex_illegal, perf_stalls
    );

    modport master (
        output if_valid, if_pc, if_instr, ex_flush,
        output rdata1, rdata2, wb_wnum, wb_wdata, wb_regwrite,
        input  id_stall, rnum1, rnum2,
        input  ex_valid, ex_pc, ex_rs1val, ex_rs2val, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
        input  ex_alusrc, ex_asel_pc, ex_memread, ex_memwrite, ex_regwrite,
        input  ex_branch, ex_jal, ex_jalr, ex_lui, ex_illegal, perf_stalls
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, operand read with writeback bypass,
// immediate/control decode, load-use hazard detection and the ID/EX register.
module id_stage (
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.slave  bus
);
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1val;
        logic [31:0] rs2val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        alusrc;
        logic        asel_pc;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        illegal;
    } idex_t;

    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_pc_reg,    ifid_pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    idex_t       idex_reg,       idex_next;
    logic [31:0] perf_reg,       perf_next;

    logic [31:0] instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    idex_t       dec;
    logic        use_rs1, use_rs2;
    logic        hazard, stall;

    logic [4:0]  rnum    [2];
    logic [31:0] rdata   [2];
    logic [31:0] operand [2];

    assign instr    = ifid_instr_reg;
    assign rnum[0]  = instr[19:15];
    assign rnum[1]  = instr[24:20];
    assign rdata[0] = bus.rdata1;
    assign rdata[1] = bus.rdata2;

    // x0 reads as zero; a same-cycle writeback beats the stale register-file value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            assign operand[gi] = (rnum[gi] == 5'd0) ? 32'h0 :
                                 (bus.wb_regwrite && bus.wb_wnum == rnum[gi]) ? bus.wb_wdata :
                                 rdata[gi];
        end
    endgenerate

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        dec.valid    = ifid_valid_reg;
        dec.pc       = ifid_pc_reg;
        dec.rs1val   = operand[0];
        dec.rs2val   = operand[1];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.funct3   = instr[14:12];
        dec.funct7b5 = instr[30];
        case (instr[6:0])
            OP_LUI:    begin dec.lui = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_u; end
            OP_AUIPC:  begin dec.asel_pc = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_u; end
            OP_JAL:    begin dec.jal = 1'b1; dec.asel_pc = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_j; end
            OP_JALR:   begin
                dec.jalr = 1'b1; dec.asel_pc = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                dec.imm = imm_i; use_rs1 = 1'b1;
            end
            OP_BRANCH: begin dec.branch = 1'b1; dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LOAD:   begin
                dec.memread = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                dec.imm = imm_i; use_rs1 = 1'b1;
            end
            OP_STORE:  begin
                dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_s;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM:    begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = imm_i; use_rs1 = 1'b1; end
            OP_OP:     begin dec.regwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default:   dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) begin
            dec.regwrite = 1'b0;
        end
    end

    // Only real register uses count, so immediates that alias rs2 bits never stall.
    assign hazard = idex_reg.valid && idex_reg.memread && (idex_reg.rd != 5'd0) && ifid_valid_reg &&
                    ((use_rs1 && idex_reg.rd == instr[19:15]) ||
                     (use_rs2 && idex_reg.rd == instr[24:20]));
    assign stall  = hazard && !bus.ex_flush;

    always_comb begin
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        if (bus.ex_flush) begin
            ifid_valid_next = 1'b0;
            ifid_pc_next    = 32'h0;
            ifid_instr_next = NOP_INSTR;
        end else if (!stall) begin
            ifid_valid_next = bus.if_valid;
            ifid_pc_next    = bus.if_pc;
            ifid_instr_next = bus.if_instr;
        end
    end

    always_comb begin
        idex_next = dec;
        if (bus.ex_flush || hazard || !ifid_valid_reg) begin
            idex_next = '0;
        end
        perf_next = stall ? perf_reg + 32'd1 : perf_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= 32'h0;
            ifid_instr_reg <= NOP_INSTR;
            idex_reg       <= '0;
            perf_reg       <= 32'h0;
        end else begin
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            idex_reg       <= idex_next;
            perf_reg       <= perf_next;
        end
    end

    assign bus.id_stall    = stall;
    assign bus.rnum1       = rnum[0];
    assign bus.rnum2       = rnum[1];
    assign bus.ex_valid    = idex_reg.valid;
    assign bus.ex_pc       = idex_reg.pc;
    assign bus.ex_rs1val   = idex_reg.rs1val;
    assign bus.ex_rs2val   = idex_reg.rs2val;
    assign bus.ex_imm      = idex_reg.imm;
    assign bus.ex_rs1      = idex_reg.rs1;
    assign bus.ex_rs2      = idex_reg.rs2;
    assign bus.ex_rd       = idex_reg.rd;
    assign bus.ex_funct3   = idex_reg.funct3;
    assign bus.ex_funct7b5 = idex_reg.funct7b5;
    assign bus.ex_alusrc   = idex_reg.alusrc;
    assign bus.ex_asel_pc  = idex_reg.asel_pc;
    assign bus.ex_memread  = idex_reg.memread;
    assign bus.ex_memwrite = idex_reg.memwrite;
    assign bus.ex_regwrite = idex_reg.regwrite;
    assign bus.ex_branch   = idex_reg.branch;
    assign bus.ex_jal      = idex_reg.jal;
    assign bus.ex_jalr     = idex_reg.jalr;
    assign bus.ex_lui      = idex_reg.lui;
    assign bus.ex_illegal  = idex_reg.illegal;
    assign bus.perf_stalls = perf_reg;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: each fetch step queues the ID/EX contents
// expected one cycle later; the queue is popped after every clock edge.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_if bus();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file model: x0 holds junk that must never reach EX, x3 reads zero.
    logic [31:0] regs [32];
    assign bus.rdata1 = regs[bus.rnum1];
    assign bus.rdata2 = regs[bus.rnum2];

    localparam logic [8:0] C_ASEL = 9'h100, C_MR = 9'h080, C_MW = 9'h040, C_RW = 9'h020,
                           C_BR = 9'h010, C_JAL = 9'h008, C_JALR = 9'h004, C_LUI = 9'h002,
                           C_ILL = 9'h001;
    localparam logic [4:0] K_IMM = 5'h01, K_R1 = 5'h02, K_R2 = 5'h04, K_RD = 5'h08, K_ALU = 5'h10;
    localparam logic [31:0] R1 = 32'h10000001, R2 = 32'h10000002, R5 = 32'h10000005,
                            R7 = 32'h10000007;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        alusrc;
        logic [8:0]  ctl;
        logic [4:0]  chk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ins(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] imm,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic alusrc,
                                 input logic [8:0] ctl, input logic [4:0] chk);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.rd = rd; e.imm = imm; e.r1 = r1; e.r2 = r2;
        e.alusrc = alusrc; e.ctl = ctl; e.chk = chk;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0; e.pc = '0; e.rd = '0; e.imm = '0; e.r1 = '0; e.r2 = '0;
        e.alusrc = 1'b0; e.ctl = '0; e.chk = 5'h1F;
        return e;
    endfunction

    function automatic logic [8:0] ctl_now();
        return {bus.ex_asel_pc, bus.ex_memread, bus.ex_memwrite, bus.ex_regwrite, bus.ex_branch,
                bus.ex_jal, bus.ex_jalr, bus.ex_lui, bus.ex_illegal};
    endfunction

    task automatic compare_ex();
        exp_t e;
        if (q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        $display("ex txn: valid=%0d pc=%h rd=%0d imm=%h rs1val=%h rs2val=%h ctl=%b",
                 bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.ex_rs1val, bus.ex_rs2val, ctl_now());
        check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.valid});
        check("ex_pc", bus.ex_pc, e.pc);
        check("ex_ctl", {23'd0, ctl_now()}, {23'd0, e.ctl});
        if (e.chk[0]) check("ex_imm", bus.ex_imm, e.imm);
        if (e.chk[1]) check("ex_rs1val", bus.ex_rs1val, e.r1);
        if (e.chk[2]) check("ex_rs2val", bus.ex_rs2val, e.r2);
        if (e.chk[3]) check("ex_rd", {27'd0, bus.ex_rd}, {27'd0, e.rd});
        if (e.chk[4]) check("ex_alusrc", {31'd0, bus.ex_alusrc}, {31'd0, e.alusrc});
    endtask

    // Called just after a falling edge; the wb_* values apply to the instruction
    // decoded this cycle (the one presented by the previous step).
    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic flush,
                        input logic wbr, input logic [4:0] wn, input logic [31:0] wd,
                        input logic stall_exp, input logic [31:0] perf_exp, input exp_t e);
        bus.if_valid    = 1'b1;
        bus.if_pc       = pc;
        bus.if_instr    = instr;
        bus.ex_flush    = flush;
        bus.wb_regwrite = wbr;
        bus.wb_wnum     = wn;
        bus.wb_wdata    = wd;
        #1;
        check("id_stall", {31'd0, bus.id_stall}, {31'd0, stall_exp});
        check("perf_stalls", bus.perf_stalls, perf_exp);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_ex();
    endtask

    task automatic drain();
        bus.if_valid    = 1'b0;
        bus.ex_flush    = 1'b0;
        bus.wb_regwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compare_ex();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        check({tag, "_pc"}, bus.ex_pc, 32'd0);
        check({tag, "_rs1val"}, bus.ex_rs1val, 32'd0);
        check({tag, "_rs2val"}, bus.ex_rs2val, 32'd0);
        check({tag, "_imm"}, bus.ex_imm, 32'd0);
        check({tag, "_regs"}, {17'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, 32'd0);
        check({tag, "_funct"}, {28'd0, bus.ex_funct3, bus.ex_funct7b5}, 32'd0);
        check({tag, "_ctl"}, {22'd0, bus.ex_alusrc, ctl_now()}, 32'd0);
        check({tag, "_perf"}, bus.perf_stalls, 32'd0);
        check({tag, "_stall"}, {31'd0, bus.id_stall}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h10000000 + i;
        regs[0] = 32'hBAD00000;
        regs[3] = 32'h0;
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.ex_flush = 1'b0;
        bus.wb_regwrite = 1'b0; bus.wb_wnum = '0; bus.wb_wdata = '0;

        #12;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(bubble());

        // Immediates and basic decode
        step(32'h00, 32'h00500093, 0, 0, 0, 0, 0, 0, ins(32'h00, 1, 32'h5, 0, 0, 1, C_RW, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h04, 32'hFE000EE3, 0, 0, 0, 0, 0, 0, ins(32'h04, 0, 32'hFFFFFFFC, 0, 0, 0, C_BR, K_IMM|K_R1|K_R2|K_ALU));
        step(32'h08, 32'hFE000E63, 0, 0, 0, 0, 0, 0, ins(32'h08, 0, 32'hFFFFF7FC, 0, 0, 0, C_BR, K_IMM|K_R1|K_R2|K_ALU));
        step(32'h0C, 32'h00208463, 0, 0, 0, 0, 0, 0, ins(32'h0C, 0, 32'h8, R1, R2, 0, C_BR, K_IMM|K_R1|K_R2|K_ALU));
        step(32'h10, 32'hFFDFF06F, 0, 0, 0, 0, 0, 0, ins(32'h10, 0, 32'hFFFFFFFC, 0, 0, 0, C_ASEL|C_JAL, K_IMM|K_RD));
        step(32'h14, 32'hFE20AE23, 0, 0, 0, 0, 0, 0, ins(32'h14, 0, 32'hFFFFFFFC, R1, R2, 1, C_MW, K_IMM|K_R1|K_R2|K_ALU));

        // Writeback bypass: hit, rs==x0 with wnum 0, and a non-matching writeback
        step(32'h18, 32'h00018233, 0, 0, 0, 0, 0, 0, ins(32'h18, 4, 0, 32'hDEADBEEF, 0, 0, C_RW, 5'h1F));
        step(32'h1C, 32'h00500093, 0, 1, 3, 32'hDEADBEEF, 0, 0, ins(32'h1C, 1, 32'h5, 0, 0, 1, C_RW, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h20, 32'h00008233, 0, 1, 0, 32'hDEADBEEF, 0, 0, ins(32'h20, 4, 0, R1, 0, 0, C_RW, 5'h1F));

        // Load-use: lw x5 then add x6,x5,x2 stalls once
        step(32'h24, 32'h0000A283, 0, 1, 3, 32'hCAFEF00D, 0, 0, ins(32'h24, 5, 0, R1, 0, 1, C_MR|C_RW, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h28, 32'h00228333, 0, 0, 0, 0, 0, 0, bubble());
        step(32'h2C, 32'h00238333, 0, 0, 0, 0, 1, 0, ins(32'h28, 6, 0, R5, R2, 0, C_RW, 5'h1F));
        check("rnum1_held", {27'd0, bus.rnum1}, 32'd5);
        step(32'h2C, 32'h00238333, 0, 0, 0, 0, 0, 1, ins(32'h2C, 6, 0, R7, R2, 0, C_RW, 5'h1F));

        // Load followed by an independent add: no stall
        step(32'h30, 32'h0000A283, 0, 0, 0, 0, 0, 1, ins(32'h30, 5, 0, R1, 0, 1, C_MR|C_RW, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h34, 32'h00238333, 0, 0, 0, 0, 0, 1, ins(32'h34, 6, 0, R7, R2, 0, C_RW, 5'h1F));

        // Load-use pair squashed by a flush in the hazard cycle
        step(32'h38, 32'h0000A283, 0, 0, 0, 0, 0, 1, ins(32'h38, 5, 0, R1, 0, 1, C_MR|C_RW, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h3C, 32'h00228333, 0, 0, 0, 0, 0, 1, bubble());
        step(32'h40, 32'h00100013, 1, 0, 0, 0, 0, 1, bubble());
        check("rnum1_nop", {27'd0, bus.rnum1}, 32'd0);
        check("rnum2_nop", {27'd0, bus.rnum2}, 32'd0);

        // Illegal opcode and rd=x0 writes
        step(32'h80, 32'h000000FF, 0, 0, 0, 0, 0, 1, ins(32'h80, 0, 0, 0, 0, 0, C_ILL, 5'h00));
        step(32'h84, 32'h00100013, 0, 0, 0, 0, 0, 1, ins(32'h84, 0, 32'h1, 0, 0, 1, 9'h000, K_IMM|K_R1|K_RD|K_ALU));
        step(32'h88, 32'h00000013, 0, 0, 0, 0, 0, 1, ins(32'h88, 0, 0, 0, 0, 1, 9'h000, K_IMM|K_R1|K_RD|K_ALU));
        drain();

        // Reset asserted between edges clears everything at once
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("midrun");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(bubble());
        step(32'h100, 32'h00500093, 0, 0, 0, 0, 0, 0, ins(32'h100, 1, 32'h5, 0, 0, 1, C_RW, K_IMM|K_R1|K_RD|K_ALU));
        drain();
        check("sb_leftover", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
